// File: rtl/mem_access_monitor.sv
// Memory access monitor: checks accepted fetch/data transfers against region permissions and tracks test exit.
// Optional watchdog (RUN -> TIMEOUT) is enabled by defining MEM_ACCESS_MONITOR_WATCHDOG_EN.
module mem_access_monitor #(
  parameter int                NUM_REGIONS    = 2,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] EXIT_ADDR      = 32'h0004_0000,
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          instr_req_i,
  input  logic                          instr_gnt_i,
  input  logic [ADDR_W-1:0]             instr_addr_i,
  input  logic                          data_req_i,
  input  logic                          data_gnt_i,
  input  logic                          data_we_i,
  input  logic [ADDR_W-1:0]             data_addr_i,
  input  logic [ADDR_W-1:0]             data_wdata_i,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_lo_i,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_hi_i,
  input  logic [NUM_REGIONS-1:0]        region_we_i,
  input  logic [NUM_REGIONS-1:0]        region_xe_i,
  output logic                          done_o,
  output logic                          pass_o,
  output logic [1:0]                    fault_code_o,
  output logic [ADDR_W-1:0]             fault_addr_o,
  output logic [15:0]                   viol_count_o,
  output logic [31:0]                   cycle_count_o
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [1:0] CODE_EXIT  = 2'b00;
  localparam logic [1:0] CODE_FETCH = 2'b01;
  localparam logic [1:0] CODE_WRITE = 2'b10;
  localparam logic [1:0] CODE_READ  = 2'b11;

  state_t state, state_nxt;
  logic   done_nxt, pass_nxt;

  logic [NUM_REGIONS-1:0] ihit, dhit;
  logic fetch_acc, data_acc, exit_wr;
  logic fetch_viol, write_viol, read_viol, data_viol, any_viol;

  // A region with lo >= hi can never satisfy lo <= addr < hi, so it never hits.
  always_comb begin
    ihit = '0;
    dhit = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      ihit[k] = (instr_addr_i >= region_lo_i[k*ADDR_W +: ADDR_W]) &&
                (instr_addr_i <  region_hi_i[k*ADDR_W +: ADDR_W]);
      dhit[k] = (data_addr_i  >= region_lo_i[k*ADDR_W +: ADDR_W]) &&
                (data_addr_i  <  region_hi_i[k*ADDR_W +: ADDR_W]);
    end
  end

  assign fetch_acc  = instr_req_i & instr_gnt_i;
  assign data_acc   = data_req_i & data_gnt_i;
  assign exit_wr    = data_acc & data_we_i & (data_addr_i == EXIT_ADDR);
  assign fetch_viol = fetch_acc & ~|(ihit & region_xe_i);
  assign write_viol = data_acc & data_we_i & ~exit_wr & ~|(dhit & region_we_i);
  assign read_viol  = data_acc & ~data_we_i & ~|dhit;
  assign data_viol  = write_viol | read_viol;
  assign any_viol   = fetch_viol | data_viol;

`ifdef MEM_ACCESS_MONITOR_WATCHDOG_EN
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
  logic wd_expired;
  assign wd_expired = (cycle_count_o >= TIMEOUT_LIM);
`else
  logic wd_expired;
  logic unused_timeout;
  assign wd_expired     = 1'b0;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_viol)       state_nxt = S_FAIL;
        else if (fetch_acc) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (any_viol)        state_nxt = S_FAIL;
        else if (exit_wr)    state_nxt = (data_wdata_i == ADDR_W'(1)) ? S_PASS : S_FAIL;
        else if (wd_expired) state_nxt = S_TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    done_nxt = (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TIMEOUT);
    pass_nxt = (state_nxt == S_PASS);
  end

  logic        first_fault;
  logic [16:0] viol_sum;
  assign first_fault = ((state == S_IDLE) || (state == S_RUN)) && (state_nxt == S_FAIL);
  assign viol_sum    = {1'b0, viol_count_o} + 17'(fetch_viol) + 17'(data_viol);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      fault_code_o  <= CODE_EXIT;
      fault_addr_o  <= '0;
      viol_count_o  <= '0;
      cycle_count_o <= '0;
    end else begin
      done_o <= done_nxt;
      pass_o <= pass_nxt;
      // Fetch outranks data; a bad exit only reaches FAIL when no violation occurred.
      if (first_fault) begin
        if (fetch_viol) begin
          fault_code_o <= CODE_FETCH;
          fault_addr_o <= instr_addr_i;
        end else if (write_viol) begin
          fault_code_o <= CODE_WRITE;
          fault_addr_o <= data_addr_i;
        end else if (read_viol) begin
          fault_code_o <= CODE_READ;
          fault_addr_o <= data_addr_i;
        end else begin
          fault_code_o <= CODE_EXIT;
          fault_addr_o <= data_wdata_i;
        end
      end
      if ((state != S_PASS) && (state != S_TIMEOUT))
        viol_count_o <= viol_sum[16] ? 16'hFFFF : viol_sum[15:0];
      if ((state == S_RUN) && (cycle_count_o != 32'hFFFF_FFFF))
        cycle_count_o <= cycle_count_o + 32'd1;
    end
  end

endmodule

// File: doc/mem_access_monitor.md
MEM_ACCESS_MONITOR -- requirements
Module: mem_access_monitor

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 2, number of address regions checked (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address and data width.
REQ-003 SHALL have parameter EXIT_ADDR, default 32'h0004_0000, exit mailbox address.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, watchdog limit in RUN cycles.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port instr_req_i / instr_gnt_i  in  1 each  fetch request / grant.
REQ-008 SHALL have port instr_addr_i  in  ADDR_W  fetch address.
REQ-009 SHALL have port data_req_i / data_gnt_i / data_we_i  in  1 each  data request / grant / write enable.
REQ-010 SHALL have port data_addr_i / data_wdata_i  in  ADDR_W each  data address / write data.
REQ-011 SHALL have port region_lo_i / region_hi_i  in  NUM_REGIONS*ADDR_W each  region bounds, region k in slice k.
REQ-012 SHALL have port region_we_i / region_xe_i  in  NUM_REGIONS each  write / execute permission per region.
REQ-013 SHALL have port done_o / pass_o  out  1 each  test finished / finished with PASS.
REQ-014 SHALL have port fault_code_o  out  2  first fault: 00 bad exit, 01 fetch, 10 write, 11 read.
REQ-015 SHALL have port fault_addr_o  out  ADDR_W  address of first fault.
REQ-016 SHALL have port viol_count_o  out  16  saturating violation count.
REQ-017 SHALL have port cycle_count_o  out  32  saturating cycles spent in RUN.

Function
REQ-018 SHALL check only accepted transfers: req & gnt high in the same cycle.
REQ-019 SHALL define a hit on region k as lo_k <= addr < hi_k, unsigned; a region with lo_k >= hi_k never hits.
REQ-020 SHALL flag a fetch violation when no hit region has xe set, a write violation when no hit region has we set, and a read violation when no region hits; overlaps pass if any hit region permits.
REQ-021 SHALL treat the EXIT_ADDR write as exempt from the write-permission check.
REQ-022 SHALL implement FSM IDLE -> RUN on the first accepted fetch; RUN -> PASS, FAIL or TIMEOUT; PASS, FAIL and TIMEOUT are sticky until reset.
REQ-023 SHALL, in RUN, go to PASS on an accepted write to EXIT_ADDR with wdata == 1, and to FAIL with code 00 and fault_addr = wdata when wdata != 1.
REQ-024 SHALL, in RUN or IDLE, go to FAIL on any violation, latching code and address of that violation only.
REQ-025 SHALL give violation priority over exit in the same cycle, and a fetch violation priority over a data violation for the latched fault fields.
REQ-026 SHALL increment viol_count by 1 per violating channel per cycle (+2 max) in IDLE, RUN and FAIL, saturating at 16'hFFFF; frozen in PASS and TIMEOUT.
REQ-027 SHALL increment cycle_count each cycle in RUN, saturating at 32'hFFFF_FFFF.
REQ-028 SHALL register all outputs; status reflects an accepted transfer one cycle after acceptance.
REQ-029 SHALL drive done_o high in PASS, FAIL and TIMEOUT, and pass_o high only in PASS.

Reset
REQ-030 SHALL on reset enter IDLE and drive done_o=0, pass_o=0, fault_code_o=00, fault_addr_o=0, viol_count_o=0, cycle_count_o=0.
REQ-031 SHALL abandon any in-progress state on reset assertion mid-run and restart from IDLE on release.

Configuration
REQ-032 SHALL, with MEM_ACCESS_MONITOR_WATCHDOG_EN defined, go RUN -> TIMEOUT in the cycle after cycle_count reaches TIMEOUT_CYCLES with no exit or violation, with done_o=1, pass_o=0, fault fields unchanged.
REQ-033 SHALL, without MEM_ACCESS_MONITOR_WATCHDOG_EN, never enter TIMEOUT and ignore TIMEOUT_CYCLES; cycle_count still counts.

Verification
REQ-034 SHALL cover: region0=[0x80,0x30080) xe, region1=[0x30080,0x40080) we; fetches at 0x80..0x100, then write 1 to 0x40000 -> done=1, pass=1, viol=0.
REQ-035 SHALL cover: fetch accepted at 0x30100 -> next cycle done=1, pass=0, code=01, addr=0x30100, viol=1.
REQ-036 SHALL cover: write to 0x100 and fetch from 0x50000 in the same cycle -> code=01, addr=0x50000, viol=2.
REQ-037 SHALL cover: write 0xDEAD to EXIT_ADDR -> FAIL, code=00, addr=0xDEAD; req without gnt to 0x0 -> no violation counted.
REQ-038 SHALL cover: with watchdog, TIMEOUT_CYCLES=50 and only legal fetches -> done=1, pass=0 after 51 RUN cycles; without macro -> done stays 0.
REQ-039 SHALL cover: reset asserted mid-RUN with viol=3 -> all outputs zero immediately, IDLE until next accepted fetch.
